// File: rtl/svx32_pkg.sv
// svx32 shared types for the data-memory arbiter.
// Imported by the arbiter top and its grant logic.
package svx32_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RSP
    } arb_state_e;

    localparam int SVX32_N_MEM_M = 2;

    function automatic logic [SVX32_N_MEM_M-1:0] idx_to_oh(
        input logic idx
    );
        idx_to_oh      = '0;
        idx_to_oh[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/svx32_rr_arbiter.sv
// Two-master grant selection: round-robin or fixed priority.
// Pure combinational; last_grant is the index of the previous winner.
module svx32_rr_arbiter
    import svx32_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic [SVX32_N_MEM_M-1:0] req,
    input  logic                     last_grant,
    output logic [SVX32_N_MEM_M-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (1'b1)
            (req == 2'b11): grant = (RR_EN && !last_grant) ? 2'b10 : 2'b01;
            (req == 2'b01): grant = 2'b01;
            (req == 2'b10): grant = 2'b10;
            default:        grant = '0;
        endcase
    end

endmodule

// File: rtl/svx32_mem_arbiter.sv
// Shares the svx32 data-memory port between the LSU and the debug/DMA master.
// One outstanding transaction; a response timeout unblocks lost reads.
module svx32_mem_arbiter
    import svx32_pkg::*;
#(
    parameter int N_M         = SVX32_N_MEM_M,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter bit RR_EN       = 1'b1,
    parameter int RSP_TIMEOUT = 16
) (
    input  logic                  pil_clk,
    input  logic                  pil_rst,
    input  logic [N_M-1:0]        piv_m_req,
    input  logic [N_M-1:0]        piv_m_wen,
    input  logic [N_M*AW-1:0]     piv_m_addr,
    input  logic [N_M*DW-1:0]     piv_m_wdata,
    input  logic [N_M*DW/8-1:0]   piv_m_byte_sel,
    output logic [N_M-1:0]        pov_m_ack,
    output logic [N_M-1:0]        pov_m_valid,
    output logic [N_M-1:0]        pov_m_err,
    output logic [DW-1:0]         pov_m_rdata,
    output logic                  pol_mem_req,
    output logic                  pol_mem_wen,
    output logic [AW-1:0]         pov_mem_addr,
    output logic [DW-1:0]         pov_mem_wdata,
    output logic [DW/8-1:0]       pov_mem_byte_sel,
    input  logic                  pil_mem_ack,
    input  logic                  pil_mem_valid,
    input  logic [DW-1:0]         piv_mem_rdata
);

    localparam int BW = DW / 8;
    localparam int CW = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

    arb_state_e     state;
    logic           gnt;
    logic           last_grant;
    logic [CW-1:0]  cnt;
    logic [N_M-1:0] grant;
    logic           sel;
    logic           timeout;
    logic [N_M-1:0] gnt_oh;

    svx32_rr_arbiter #(
        .RR_EN(RR_EN)
    ) u_rr (
        .req       (piv_m_req),
        .last_grant(last_grant),
        .grant     (grant)
    );

    assign sel     = grant[1];
    assign gnt_oh  = idx_to_oh(gnt);
    assign timeout = (state == ARB_RSP) && (cnt == CNT_LAST);

    always_ff @(posedge pil_clk) begin
        if (pil_rst) begin
            state            <= ARB_IDLE;
            gnt              <= 1'b0;
            last_grant       <= 1'b1;
            cnt              <= '0;
            pol_mem_req      <= 1'b0;
            pol_mem_wen      <= 1'b0;
            pov_mem_addr     <= '0;
            pov_mem_wdata    <= '0;
            pov_mem_byte_sel <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (|grant) begin
                        gnt              <= sel;
                        last_grant       <= sel;
                        pol_mem_req      <= 1'b1;
                        pol_mem_wen      <= piv_m_wen[sel];
                        pov_mem_addr     <= piv_m_addr[int'(sel)*AW +: AW];
                        pov_mem_wdata    <= piv_m_wdata[int'(sel)*DW +: DW];
                        pov_mem_byte_sel <= piv_m_byte_sel[int'(sel)*BW +: BW];
                        state            <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (pil_mem_ack) begin
                        pol_mem_req <= 1'b0;
                        cnt         <= '0;
                        state       <= pol_mem_wen ? ARB_IDLE : ARB_RSP;
                    end
                end
                ARB_RSP: begin
                    if (pil_mem_valid || timeout) begin
                        state <= ARB_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Responses route only to the registered winner; a real valid beats a timeout.
    always_comb begin
        pov_m_ack   = '0;
        pov_m_valid = '0;
        pov_m_err   = '0;
        pov_m_rdata = '0;
        unique case (state)
            ARB_REQ: begin
                if (pil_mem_ack) pov_m_ack = gnt_oh;
            end
            ARB_RSP: begin
                if (pil_mem_valid) begin
                    pov_m_valid = gnt_oh;
                    pov_m_rdata = piv_mem_rdata;
                end else if (timeout) begin
                    pov_m_valid = gnt_oh;
                    pov_m_err   = gnt_oh;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_svx32_mem_arbiter.sv
// Directed bench for svx32_mem_arbiter: round-robin/timeout instance
// plus a fixed-priority instance for the starvation case.
module tb_svx32_mem_arbiter;

    logic        pil_clk;
    logic        pil_rst;
    logic [1:0]  m_req, m_wen;
    logic [63:0] m_addr, m_wdata;
    logic [7:0]  m_bsel;
    logic [1:0]  ack, valid, err;
    logic [31:0] rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_bsel;
    logic        mem_ack, mem_valid;
    logic [31:0] mem_rdata;

    logic [1:0]  fp_req, fp_wen;
    logic [63:0] fp_addr, fp_wdata;
    logic [7:0]  fp_bsel;
    logic [1:0]  fp_ack, fp_valid, fp_err;
    logic [31:0] fp_rdata;
    logic        fp_mem_req, fp_mem_wen;
    logic [31:0] fp_mem_addr, fp_mem_wdata;
    logic [3:0]  fp_mem_bsel;
    logic        fp_mem_ack, fp_mem_valid;
    logic [31:0] fp_mem_rdata;

    int checks = 0;
    int errors = 0;
    int n0, n1;

    svx32_mem_arbiter #(.RR_EN(1'b1), .RSP_TIMEOUT(8)) u_dut (
        .pil_clk(pil_clk), .pil_rst(pil_rst),
        .piv_m_req(m_req), .piv_m_wen(m_wen), .piv_m_addr(m_addr),
        .piv_m_wdata(m_wdata), .piv_m_byte_sel(m_bsel),
        .pov_m_ack(ack), .pov_m_valid(valid), .pov_m_err(err),
        .pov_m_rdata(rdata),
        .pol_mem_req(mem_req), .pol_mem_wen(mem_wen),
        .pov_mem_addr(mem_addr), .pov_mem_wdata(mem_wdata),
        .pov_mem_byte_sel(mem_bsel),
        .pil_mem_ack(mem_ack), .pil_mem_valid(mem_valid),
        .piv_mem_rdata(mem_rdata)
    );

    svx32_mem_arbiter #(.RR_EN(1'b0), .RSP_TIMEOUT(16)) u_fp (
        .pil_clk(pil_clk), .pil_rst(pil_rst),
        .piv_m_req(fp_req), .piv_m_wen(fp_wen), .piv_m_addr(fp_addr),
        .piv_m_wdata(fp_wdata), .piv_m_byte_sel(fp_bsel),
        .pov_m_ack(fp_ack), .pov_m_valid(fp_valid), .pov_m_err(fp_err),
        .pov_m_rdata(fp_rdata),
        .pol_mem_req(fp_mem_req), .pol_mem_wen(fp_mem_wen),
        .pov_mem_addr(fp_mem_addr), .pov_mem_wdata(fp_mem_wdata),
        .pov_mem_byte_sel(fp_mem_bsel),
        .pil_mem_ack(fp_mem_ack), .pil_mem_valid(fp_mem_valid),
        .piv_mem_rdata(fp_mem_rdata)
    );

    assign fp_mem_ack = fp_mem_req;

    initial pil_clk = 1'b0;
    always #5 pil_clk = ~pil_clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge pil_clk);
    endtask

    initial begin
        pil_rst = 1'b1;
        m_req = '0; m_wen = '0; m_addr = '0; m_wdata = '0; m_bsel = '0;
        mem_ack = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        fp_req = '0; fp_wen = 2'b11; fp_wdata = '0; fp_bsel = 8'hFF;
        fp_addr = {32'h0000_0B00, 32'h0000_0A00};
        fp_mem_valid = 1'b0; fp_mem_rdata = '0;
        cyc(); cyc();

        // reset state
        cyc(); pil_rst = 1'b0; #1;
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_outs", {26'd0, ack, valid, err}, 0);
        chk("rst_addr", mem_addr, 0);

        // M0 read, ack +2, valid +2
        cyc(); m_req = 2'b01; m_wen = 2'b00; m_addr[31:0] = 32'h0000_0100; #1;
        chk("rd_lat0", {31'd0, mem_req}, 0);
        cyc(); #1;
        chk("rd_req", {31'd0, mem_req}, 1);
        chk("rd_addr", mem_addr, 32'h0000_0100);
        chk("rd_wen", {31'd0, mem_wen}, 0);
        chk("rd_noack", {30'd0, ack}, 0);
        cyc(); #1;
        chk("rd_noack2", {30'd0, ack}, 0);
        cyc(); mem_ack = 1'b1; #1;
        chk("rd_ack", {30'd0, ack}, 32'h1);
        cyc(); mem_ack = 1'b0; m_req = 2'b00; #1;
        chk("rd_req_drop", {31'd0, mem_req}, 0);
        chk("rd_novalid", {30'd0, valid}, 0);
        cyc(); mem_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF; #1;
        chk("rd_valid", {28'd0, valid, err}, 32'h4);
        chk("rd_data", rdata, 32'hDEAD_BEEF);
        cyc(); mem_valid = 1'b0; #1;
        chk("rd_valid_end", {30'd0, valid}, 0);

        // round-robin from a fresh reset
        pil_rst = 1'b1;
        cyc(); pil_rst = 1'b0;
        m_addr = {32'h0000_0080, 32'h0000_0040};
        for (int t = 0; t < 4; t++) begin
            logic [1:0] exp_oh;
            exp_oh = (t % 2 == 0) ? 2'b01 : 2'b10;
            if (t > 0) cyc();
            mem_valid = 1'b0; m_req = 2'b11; #1;
            chk("rr_bubble", {31'd0, mem_req}, 0);
            cyc(); mem_ack = 1'b1; #1;
            chk("rr_ack", {30'd0, ack}, {30'd0, exp_oh});
            chk("rr_addr", mem_addr, exp_oh[0] ? 32'h40 : 32'h80);
            cyc(); mem_ack = 1'b0; mem_valid = 1'b1; mem_rdata = t; #1;
            chk("rr_valid", {30'd0, valid}, {30'd0, exp_oh});
        end

        // M1 write held three cycles before ack
        cyc(); mem_valid = 1'b0; m_req = 2'b10; m_wen = 2'b10;
        m_addr[63:32] = 32'h20; m_wdata[63:32] = 32'h1234_5678;
        m_bsel[7:4] = 4'b0011; #1;
        chk("wr_idle", {31'd0, mem_req}, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); mem_ack = (k == 2); #1;
            chk("wr_fields", {mem_req, mem_wen, mem_bsel, 26'd0},
                {1'b1, 1'b1, 4'b0011, 26'd0});
            chk("wr_addr", mem_addr, 32'h20);
            chk("wr_wdata", mem_wdata, 32'h1234_5678);
            chk("wr_ack", {30'd0, ack}, (k == 2) ? 32'h2 : 32'h0);
        end

        // M0 read that times out; next cycle must be IDLE to grant it
        cyc(); mem_ack = 1'b0; m_req = 2'b01; m_wen = 2'b00;
        m_addr[31:0] = 32'h300; mem_rdata = 32'hA5A5_A5A5; #1;
        chk("wr_novalid", {30'd0, valid}, 0);
        cyc(); mem_ack = 1'b1; #1;
        chk("to_ack", {30'd0, ack}, 32'h1);
        chk("to_addr", mem_addr, 32'h300);
        for (int k = 1; k <= 11; k++) begin
            cyc(); mem_ack = 1'b0; m_req = 2'b00;
            mem_valid = (k == 10); #1;
            if (k == 8) begin
                chk("to_pulse", {28'd0, valid, err}, 32'h5);
                chk("to_rdata", rdata, 0);
            end else begin
                chk("to_quiet", {28'd0, valid, err}, 0);
            end
        end

        // reset while in RSP, stale valid, then M1 write
        mem_valid = 1'b0; m_req = 2'b01; m_addr[31:0] = 32'h400; #1;
        cyc(); mem_ack = 1'b1; #1;
        chk("rs_ack", {30'd0, ack}, 32'h1);
        cyc(); mem_ack = 1'b0; m_req = 2'b00; pil_rst = 1'b1; #1;
        chk("rs_rsp_quiet", {30'd0, valid}, 0);
        cyc(); pil_rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'hBAD;
        m_req = 2'b10; m_wen = 2'b10; m_addr[63:32] = 32'h500; #1;
        chk("rs_regs", {mem_req, mem_wen, mem_bsel, 26'd0}, 0);
        chk("rs_addr", mem_addr, 0);
        chk("rs_wdata", mem_wdata, 0);
        chk("rs_outs", {26'd0, ack, valid, err}, 0);
        chk("rs_rdata", rdata, 0);
        cyc(); mem_valid = 1'b0; mem_ack = 1'b1; #1;
        chk("rs_m1_req", {30'd0, mem_req, mem_wen}, 32'h3);
        chk("rs_m1_addr", mem_addr, 32'h500);
        chk("rs_m1_ack", {30'd0, ack}, 32'h2);
        cyc(); mem_ack = 1'b0; m_req = 2'b00; #1;
        chk("rs_m1_done", {30'd0, mem_req, valid[1]}, 0);

        // fixed priority: M1 starves while M0 keeps requesting
        n0 = 0; n1 = 0;
        cyc(); fp_req = 2'b11;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) cyc();
            #1;
            n0 += int'(fp_ack[0]);
            n1 += int'(fp_ack[1]);
        end
        chk("fp_m0_cnt", n0, 20);
        chk("fp_m1_cnt", n1, 0);
        cyc(); fp_req = 2'b10; #1;
        chk("fp_idle", {31'd0, fp_mem_req}, 0);
        cyc(); #1;
        chk("fp_m1_ack", {30'd0, fp_ack}, 32'h2);
        chk("fp_m1_addr", fp_mem_addr, 32'h0B00);
        fp_req = 2'b00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
